// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel button/switch debouncer.
package debounce_pkg;

    // Sample-tick prescaler values for a 10 ms tick on common board clocks.
    localparam int TICK_DIV_50MHZ   = 500000;
    localparam int TICK_DIV_100MHZ  = 1000000;
    localparam int TICK_DIV_DEFAULT = TICK_DIV_50MHZ;

    // Raw pin level of a released button for each polarity.
    localparam logic IDLE_ACTIVE_LOW  = 1'b1;
    localparam logic IDLE_ACTIVE_HIGH = 1'b0;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic logic idle_level(input logic active_low);
        return active_low ? IDLE_ACTIVE_LOW : IDLE_ACTIVE_HIGH;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: 2-flop synchroniser, stability counter, debounced
// level register and registered press/release pulses. Advances only on the
// shared sample tick, which is already gated by enable in the top level.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = 4,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int             CW   = clog2(STABLE_TICKS) + 1;
    localparam logic [CW-1:0]  LAST = CW'(STABLE_TICKS - 1);
    localparam logic           IDLE = idle_level(ACTIVE_LOW != 0);

    logic          sync_0;
    logic          sync_1;
    logic          lvl;
    logic          prev;
    logic [CW-1:0] stable_cnt;

    // Bring the raw pin into the clock domain; reset to the released level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_0 <= IDLE;
            sync_1 <= IDLE;
        end else begin
            sync_0 <= raw;
            sync_1 <= sync_0;
        end
    end

    assign lvl = (ACTIVE_LOW != 0) ? ~sync_1 : sync_1;

    // On each tick: agreement clears the count, STABLE_TICKS disagreements flip the level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stable_cnt <= '0;
            level      <= 1'b0;
        end else if (tick) begin
            if (lvl == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == LAST) begin
                level      <= lvl;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

    // Edge pulses, one clock after the debounced level changes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev          <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            prev          <= level;
            press_pulse   <= level & ~prev;
            release_pulse <= ~level & prev;
        end
    end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel button/switch conditioner. A single prescaler produces the
// sample tick shared by every channel; each channel debounces independently.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int TICK_DIV     = TICK_DIV_DEFAULT,
    parameter int STABLE_TICKS = 4,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] pb,
    input  logic                enable,
    output logic [CHANNELS-1:0] pb_debounced,
    output logic [CHANNELS-1:0] pb_press,
    output logic [CHANNELS-1:0] pb_release,
    output logic                tick
);

    localparam int            PW = clog2(TICK_DIV);
    localparam logic [PW-1:0] TC = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_cnt;

    // Tick is combinational so it lines up with the terminal count and drops with enable.
    assign tick = enable & (pre_cnt == TC);

    // Prescaler: 0..TICK_DIV-1 while enabled, frozen otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (enable) begin
            pre_cnt <= (pre_cnt == TC) ? '0 : pre_cnt + PW'(1);
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_chan (
            .clock         (clock),
            .reset_n       (reset_n),
            .tick          (tick),
            .raw           (pb[ch]),
            .level         (pb_debounced[ch]),
            .press_pulse   (pb_press[ch]),
            .release_pulse (pb_release[ch])
        );
    end

endmodule
